// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if : request/result bundle between the EX stage and the multiply/divide
//          unit.
//   start  : one-cycle request strobe (master -> mdu)
//   MDUOp  : 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//            110/111 no-op (master -> mdu)
//   A, B   : rs / rt operands (master -> mdu)
//   busy   : operation in flight (mdu -> master)
//   HI, LO : architectural HI/LO registers (mdu -> master)
// -----------------------------------------------------------------------------
interface mdu_if;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, MDUOp, A, B, input  busy, HI, LO);
    modport slave  (input  start, MDUOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu : multi-cycle multiply/divide unit beside the EX-stage ALU.
//   The result is computed combinationally from the operands at the accept
//   edge, parked in hi_tmp/lo_tmp, and committed to HI/LO after a fixed
//   latency (MULT_CYCLES or DIV_CYCLES) so the stall timing matches a real
//   iterative multiplier/divider.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mdu_if.slave (start, MDUOp, A, B in; busy, HI, LO out)
// Configuration:
//   MDU_DIV_EN : when defined, div/divu are built; otherwise ops 010/011 are
//                treated as no-ops.
// -----------------------------------------------------------------------------
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          wr_q, wr_d;     // clear for divide-by-zero: commit leaves HI/LO alone

    // Full 64-bit products; operands are extended first so the low 64 bits
    // of the product are exact.
    logic signed [63:0] a_s, b_s, prod_s;
    logic        [63:0] prod_u;
    assign a_s    = {{32{bus.A[31]}}, bus.A};
    assign b_s    = {{32{bus.B[31]}}, bus.B};
    assign prod_s = a_s * b_s;
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

`ifdef MDU_DIV_EN
    // Divisor forced to 1 on zero so the dividers never produce X; the
    // result is discarded anyway via wr_q.
    logic        div_zero;
    logic [31:0] divisor, quot_s, rem_s, quot_u, rem_u;
    assign div_zero = (bus.B == 32'd0);
    assign divisor  = div_zero ? 32'd1 : bus.B;
    assign quot_s   = $signed(bus.A) / $signed(divisor);
    assign rem_s    = $signed(bus.A) % $signed(divisor);
    assign quot_u   = bus.A / divisor;
    assign rem_u    = bus.A % divisor;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        wr_d     = wr_q;
        if (state_q == S_IDLE) begin
            if (bus.start) begin
                case (bus.MDUOp)
                    OP_MULT: begin
                        state_d              = S_RUN;
                        cnt_d                = CW'(MULT_CYCLES);
                        {hi_tmp_d, lo_tmp_d} = prod_s;
                        wr_d                 = 1'b1;
                    end
                    OP_MULTU: begin
                        state_d              = S_RUN;
                        cnt_d                = CW'(MULT_CYCLES);
                        {hi_tmp_d, lo_tmp_d} = prod_u;
                        wr_d                 = 1'b1;
                    end
`ifdef MDU_DIV_EN
                    OP_DIV: begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(DIV_CYCLES);
                        hi_tmp_d = rem_s;
                        lo_tmp_d = quot_s;
                        wr_d     = ~div_zero;
                    end
                    OP_DIVU: begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(DIV_CYCLES);
                        hi_tmp_d = rem_u;
                        lo_tmp_d = quot_u;
                        wr_d     = ~div_zero;
                    end
`endif
                    OP_MTHI: hi_d = bus.A;
                    OP_MTLO: lo_d = bus.A;
                    default: ;
                endcase
            end
        end else begin
            // start is ignored in RUN; nothing is queued.
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = S_IDLE;
                if (wr_q) begin
                    hi_d = hi_tmp_q;
                    lo_d = lo_tmp_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wr_q     <= wr_d;
        end
    end

    // The state flop itself is the registered busy.
    assign bus.busy = (state_q == S_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU in the EX stage. It accepts a one-cycle `start` request carrying an operation and two 32-bit operands, holds `busy` for a fixed number of cycles, then commits the result into the architectural HI/LO registers. The stall controller watches `busy` and `start` to hold later HI/LO-dependent instructions. The combinational ALU answers within the same cycle; this unit answers over several cycles.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (must be ≥1).

- `clk` input 1: single clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: request strobe, sampled on the rising edge.
- `MDUOp` input 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
- `A` input 32: rs operand (dividend / multiplicand / mthi-mtlo source).
- `B` input 32: rt operand (divisor / multiplier).
- `busy` output 1: operation in flight.
- `HI` output 32: architectural HI.
- `LO` output 32: architectural LO.

## Operation
- State: IDLE, RUN. Registers: `cnt` (4 bits minimum, wide enough for max(MULT_CYCLES, DIV_CYCLES)), `hi_tmp`, `lo_tmp`, HI, LO.
- Accept condition: `start`=1 and state IDLE. In RUN, `start` is ignored entirely (no queueing); the stall controller must not issue in that case.
- mult: {hi_tmp,lo_tmp} = 64-bit $signed(A)*$signed(B). multu: unsigned 64-bit product.
- div: lo_tmp = $signed(A)/$signed(B) truncated toward zero; hi_tmp = remainder with sign of A. divu: unsigned quotient/remainder.
- Divide by zero: operation is accepted and runs DIV_CYCLES, but HI and LO are left unchanged at commit.
- Result is computed at the accept edge from the operands present then; later changes to A/B do not affect it.
- IDLE→RUN on accept of mult/multu/div/divu: `cnt` loads MULT_CYCLES or DIV_CYCLES; busy=1.
- RUN: `cnt` decrements each edge. On the edge where `cnt`=1: HI<=hi_tmp, LO<=lo_tmp, busy<=0, state IDLE.
- mthi/mtlo on accept: HI<=A or LO<=A at that same edge. No RUN, busy stays 0.
- Op 110/111 on accept: no effect.

## Timing
- Reset (async, any time including mid-RUN): state IDLE, busy=0, cnt=0, HI=0, LO=0, temps=0. The in-flight result is discarded.
- busy is a registered output. It rises the cycle after the accept edge and stays high for exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO show the new value in the same cycle busy falls, N edges after the accept edge.
- mthi/mtlo: the new value is visible one cycle after the accept edge.
- Back-to-back: a `start` in the cycle busy is low (including the cycle right after commit) is accepted. The sequence result-commit edge → next-accept edge has zero dead cycles.
- Reading HI/LO while busy returns the previous committed values.

## Configuration
- `MDU_DIV_EN` defined: div/divu are implemented as described.
- `MDU_DIV_EN` undefined: divider logic is not built. Ops 010/011 are treated as no-ops (busy stays 0, HI/LO unchanged). mult/multu/mthi/mtlo are unaffected.

## Test plan
- Reset then mult with A=0xFFFFFFFE (−2), B=3 → busy high for 5 cycles. At fall, HI=0xFFFFFFFF, LO=0xFFFFFFFA. With multu on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div with A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → busy never rises; HI/LO take those values one cycle after each accept.
- div with B=0 after mthi 0x11/mtlo 0x22 → busy for 10 cycles, HI=0x11 and LO=0x22 unchanged. Also: `start` with mult asserted while busy → ignored, HI/LO reflect only the first op.
- Assert reset in the 3rd busy cycle of a mult → busy=0, HI=LO=0 immediately, and no later commit.
- Build without `MDU_DIV_EN`: div A=8, B=2 → busy stays 0, HI/LO unchanged. mult 3×4 → LO=12, HI=0 after 5 cycles.
